// File: rtl/lexer_stream_if.sv
// Byte-in / token-out handshake bundle for lexer_stream.
//   I_VALID/I_READY/I_DATA : ASCII source bytes into the lexer
//   O_VALID/O_READY/O_DATA : {tag[7:0], value[NUM_WIDTH-1:0]} tokens out
// slave  : the lexer side (consumes bytes, produces tokens)
// master : the producer/consumer side (testbench or upstream/downstream logic)
interface lexer_stream_if #(
  parameter int NUM_WIDTH = 8
);
  logic                   I_VALID;
  logic                   I_READY;
  logic [7:0]             I_DATA;
  logic                   O_VALID;
  logic                   O_READY;
  logic [8+NUM_WIDTH-1:0] O_DATA;

  modport slave (
    input  I_VALID, I_DATA, O_READY,
    output I_READY, O_VALID, O_DATA
  );

  modport master (
    output I_VALID, I_DATA, O_READY,
    input  I_READY, O_VALID, O_DATA
  );
endinterface

// File: rtl/lexer_stream.sv
// Streaming lexer: ASCII bytes in, fixed-width {tag, value} tokens out through
// a first-word-fall-through token FIFO with backpressure.
// Ports:
//   CLK        rising-edge clock
//   RST_N      asynchronous active-low reset
//   bus        lexer_stream_if.slave (byte input and token output handshakes)
//   FOUND_EOF  sticky, set on the edge the EOF token is written
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | between tokens; letters/digits start a word/number
// WORD  | collecting letters/digits of a word (last 3 chars kept)
// NUM   | accumulating a decimal literal
// PEND  | terminator token held until the FIFO has room
// DONE  | end of stream seen; input closed until reset, FIFO drains
module lexer_stream #(
  parameter int NUM_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  lexer_stream_if.slave bus,
  output logic          FOUND_EOF
);

  localparam int DW    = 8 + NUM_WIDTH;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int ACC_W = NUM_WIDTH + 4;
  localparam logic [ACC_W-1:0] NUM_MAX = ACC_W'((1 << NUM_WIDTH) - 1);

  localparam logic [7:0] TAG_NUM    = 8'h00;
  localparam logic [7:0] TAG_OUT    = 8'h01;
  localparam logic [7:0] TAG_VAR_A  = 8'h02;
  localparam logic [7:0] TAG_EQUAL  = 8'h03;
  localparam logic [7:0] TAG_VAR_B  = 8'h04;
  localparam logic [7:0] TAG_VAR_C  = 8'h05;
  localparam logic [7:0] TAG_IF     = 8'h06;
  localparam logic [7:0] TAG_LPAREN = 8'h07;
  localparam logic [7:0] TAG_RPAREN = 8'h08;
  localparam logic [7:0] TAG_PLUS   = 8'h09;
  localparam logic [7:0] TAG_MINUS  = 8'h0a;
  localparam logic [7:0] TAG_SEMI   = 8'h0b;
  localparam logic [7:0] TAG_EOF    = 8'h0c;
  localparam logic [7:0] TAG_ERROR  = 8'hff;

  typedef enum logic [2:0] {S_IDLE, S_WORD, S_NUM, S_PEND, S_DONE} state_t;

  state_t           state;
  logic [23:0]      word_buf;   // newest char in [7:0]
  logic [2:0]       word_len;   // saturates at 4 so long words never alias short ones
  logic [ACC_W-1:0] acc;
  logic             num_ovf;
  logic             num_bad;
  logic [7:0]       pend_tag;

  logic [DW-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [DW-1:0]    push_data;

  logic [7:0]       in_byte;
  logic             is_ws, is_end, is_dig, is_let, is_punct, is_bad;
  logic [7:0]       punct_tag;
  logic [7:0]       term_tag;
  logic [7:0]       word_tag;
  logic [ACC_W-1:0] acc_next;
  logic [DW-1:0]    num_tok;
  logic             in_ready;
  logic             accept;

  function automatic logic [DW-1:0] tag_tok(input logic [7:0] tag);
    return {tag, {NUM_WIDTH{1'b0}}};
  endfunction

  assign in_byte = bus.I_DATA;
  assign is_ws   = (in_byte == 8'h09) || (in_byte == 8'h0a) ||
                   (in_byte == 8'h0d) || (in_byte == 8'h20);
  assign is_end  = (in_byte == 8'h00) || (in_byte == 8'hff);
  assign is_dig  = (in_byte >= 8'h30) && (in_byte <= 8'h39);
  assign is_let  = ((in_byte >= 8'h41) && (in_byte <= 8'h5a)) ||
                   ((in_byte >= 8'h61) && (in_byte <= 8'h7a));

  always_comb begin
    punct_tag = TAG_ERROR;
    is_punct  = 1'b1;
    case (in_byte)
      8'h28:   punct_tag = TAG_LPAREN;
      8'h29:   punct_tag = TAG_RPAREN;
      8'h3d:   punct_tag = TAG_EQUAL;
      8'h2b:   punct_tag = TAG_PLUS;
      8'h2d:   punct_tag = TAG_MINUS;
      8'h3b:   punct_tag = TAG_SEMI;
      default: is_punct  = 1'b0;
    endcase
  end

  assign is_bad   = !(is_ws || is_end || is_dig || is_let || is_punct);
  // Token a non-whitespace terminator leaves behind after the pending word/number.
  assign term_tag = is_end ? TAG_EOF : (is_punct ? punct_tag : TAG_ERROR);

  always_comb begin
    word_tag = TAG_ERROR;
    case (word_len)
      3'd1: begin
        case (word_buf[7:0])
          8'h61:   word_tag = TAG_VAR_A;
          8'h62:   word_tag = TAG_VAR_B;
          8'h63:   word_tag = TAG_VAR_C;
          default: word_tag = TAG_ERROR;
        endcase
      end
      3'd2: if (word_buf[15:0] == 16'h6966) word_tag = TAG_IF;
      3'd3: begin
        if (word_buf == 24'h6f7574)      word_tag = TAG_OUT;
        else if (word_buf == 24'h454f46) word_tag = TAG_EOF;
      end
      default: word_tag = TAG_ERROR;
    endcase
  end

  // Extra 4 bits hold acc*10+9 for any in-range acc, so the overflow compare is exact.
  assign acc_next = acc * ACC_W'(10) + ACC_W'(in_byte[3:0]);
  assign num_tok  = (num_ovf || num_bad) ? tag_tok(TAG_ERROR)
                                         : {TAG_NUM, acc[NUM_WIDTH-1:0]};

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign in_ready = RST_N && !full &&
                    ((state == S_IDLE) || (state == S_WORD) || (state == S_NUM));
  assign accept   = bus.I_VALID && in_ready;
  assign pop      = !empty && bus.O_READY;

  assign bus.I_READY = in_ready;
  assign bus.O_VALID = !empty;
  assign bus.O_DATA  = empty ? '0 : mem[rd_ptr];

  always_comb begin
    push      = 1'b0;
    push_data = '0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (is_end) begin
            push      = 1'b1;
            push_data = tag_tok(TAG_EOF);
          end else if (is_punct || is_bad) begin
            push      = 1'b1;
            push_data = tag_tok(term_tag);
          end
        end
      end
      S_WORD: begin
        if (accept && !(is_let || is_dig)) begin
          push      = 1'b1;
          push_data = tag_tok(word_tag);
        end
      end
      S_NUM: begin
        if (accept && !(is_let || is_dig)) begin
          push      = 1'b1;
          push_data = num_tok;
        end
      end
      S_PEND: begin
        if (!full) begin
          push      = 1'b1;
          push_data = tag_tok(pend_tag);
        end
      end
      default: begin
        push      = 1'b0;
        push_data = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      word_buf  <= '0;
      word_len  <= '0;
      acc       <= '0;
      num_ovf   <= 1'b0;
      num_bad   <= 1'b0;
      pend_tag  <= '0;
      FOUND_EOF <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_let) begin
              state    <= S_WORD;
              word_buf <= {16'h0000, in_byte};
              word_len <= 3'd1;
            end else if (is_dig) begin
              state   <= S_NUM;
              acc     <= ACC_W'(in_byte[3:0]);
              num_ovf <= 1'b0;
              num_bad <= 1'b0;
            end else if (is_end) begin
              state     <= S_DONE;
              FOUND_EOF <= 1'b1;
            end
          end
        end
        S_WORD: begin
          if (accept) begin
            if (is_let || is_dig) begin
              word_buf <= {word_buf[15:0], in_byte};
              word_len <= (word_len == 3'd4) ? 3'd4 : word_len + 3'd1;
            end else if (word_tag == TAG_EOF) begin
              // The "EOF" word closes the stream; its terminator is consumed.
              state     <= S_DONE;
              FOUND_EOF <= 1'b1;
            end else if (is_ws) begin
              state <= S_IDLE;
            end else begin
              state    <= S_PEND;
              pend_tag <= term_tag;
            end
          end
        end
        S_NUM: begin
          if (accept) begin
            if (is_dig) begin
              acc <= acc_next;
              if (acc_next > NUM_MAX) num_ovf <= 1'b1;
            end else if (is_let) begin
              num_bad <= 1'b1;
            end else if (is_ws) begin
              state <= S_IDLE;
            end else begin
              state    <= S_PEND;
              pend_tag <= term_tag;
            end
          end
        end
        S_PEND: begin
          if (!full) begin
            if (pend_tag == TAG_EOF) begin
              state     <= S_DONE;
              FOUND_EOF <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_DONE:  state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: O_DATA is forced to zero while the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule
